csi2_pkt_mux: RTL and testbench
===============================

CSI2_PKT_MUX -- requirements
Module: csi2_pkt_mux

Interface
REQ-001 SHALL have parameter RX_DATA_WIDTH, default 8, payload bus width per channel (RX_GEAR*LANE_COUNT, multiple of 8).
REQ-002 SHALL have parameter NUM_CH, default 4, number of input channels (2..8).
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = host-selected channel, 1 = round-robin packet arbitration.
REQ-004 SHALL have parameter VC_REMAP, default 0: 1 = output VC replaced by winning channel index[1:0].
REQ-005 SHALL have localparam SELW = clog2(NUM_CH), and localparam BPB = RX_DATA_WIDTH/8, bytes per beat.
REQ-006 clk_byte  input  1  byte clock; all logic on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 mux_sel  input  SELW  requested channel (ARB_MODE 0 only).
REQ-009 lp_en  input  NUM_CH  per-channel long-packet header strobe.
REQ-010 sp_en  input  NUM_CH  per-channel short-packet strobe.
REQ-011 d2c_payload_en  input  NUM_CH  per-channel payload valid.
REQ-012 d2c_data  input  NUM_CH*RX_DATA_WIDTH  channel i at [i*RX_DATA_WIDTH +: RX_DATA_WIDTH].
REQ-013 wc / vc / dt  input  NUM_CH*16 / NUM_CH*2 / NUM_CH*6  per-channel header fields, packed likewise.
REQ-014 lp_en_mux, sp_en_mux, d2c_payload_en_mux  output  1 each  registered muxed strobes.
REQ-015 d2c_data_mux  output  RX_DATA_WIDTH; wc_mux 16; vc_mux 2; dt_mux 6  registered muxed fields.
REQ-016 cur_ch  output  SELW  channel currently owning the output.
REQ-017 drop_cnt  output  16  saturating count of discarded packets.

Function
REQ-018 SHALL use FSM states IDLE and LONG; all outputs registered, 1-cycle latency from input to output.
REQ-019 In IDLE, candidate channel = mux_sel (ARB_MODE 0) or first channel with lp_en|sp_en searching from (last_grant+1) mod NUM_CH upward (ARB_MODE 1).
REQ-020 In IDLE, sp_en on candidate SHALL forward sp_en_mux=1 with candidate's wc/vc/dt next cycle; FSM stays IDLE; last_grant := candidate.
REQ-021 In IDLE, lp_en on candidate SHALL forward lp_en_mux=1 with header fields, latch wc into byte_rem, set owner := candidate, last_grant := candidate, go to LONG.
REQ-022 If candidate has both lp_en and sp_en in one cycle, lp_en SHALL win and the short packet SHALL be counted as dropped.
REQ-023 In LONG, only the owner's payload_en/data SHALL be forwarded; byte_rem decrements by BPB per payload beat.
REQ-024 LONG SHALL return to IDLE on the beat where byte_rem <= BPB (final beat forwarded), or on owner wc==0 immediately after the header cycle.
REQ-025 mux_sel changes SHALL take effect only in IDLE; no mid-packet switch.
REQ-026 Every lp_en/sp_en on a non-winning channel (any state), and on the owner while in LONG, SHALL increment drop_cnt by the number of such strobes that cycle; drop_cnt saturates at 0xFFFF.
REQ-027 Payload of non-owner channels SHALL never reach outputs.
REQ-028 When no strobe/payload is forwarded, lp_en_mux, sp_en_mux, d2c_payload_en_mux SHALL be 0; data/wc/vc/dt hold last value.
REQ-029 With VC_REMAP=1, vc_mux SHALL equal winning channel index[1:0]; otherwise source vc.
REQ-030 cur_ch SHALL equal owner in LONG and last_grant in IDLE.

Reset
REQ-031 On reset: FSM=IDLE, all strobes 0, d2c_data_mux/wc_mux/vc_mux/dt_mux=0, cur_ch=0, drop_cnt=0, byte_rem=0, last_grant=NUM_CH-1 (so channel 0 has first priority).
REQ-032 Reset asserted mid-LONG SHALL abort the packet; no further payload beats forwarded after reset cycle.

Verification
REQ-033 ARB_MODE 0, mux_sel=2, lp_en[2] with wc=4, RX_DATA_WIDTH=8, 4 payload beats -> lp_en_mux 1 cycle later, 4 d2c_payload_en_mux beats, return to IDLE, drop_cnt=0.
REQ-034 ARB_MODE 1, lp_en[0] and lp_en[3] same cycle after reset -> channel 0 wins, cur_ch=0, drop_cnt=1; next simultaneous pair [0],[3] -> channel 3 wins.
REQ-035 mux_sel changed 1->3 during channel 1 long packet -> remaining channel 1 payload forwarded; channel 3 selected only after packet end.
REQ-036 sp_en[1] while channel 2 in LONG -> drop_cnt increments by 1, sp_en_mux stays 0.
REQ-037 VC_REMAP=1, sp_en[3] with vc=0 -> vc_mux=3; drop_cnt forced past 0xFFFF -> holds 0xFFFF.
REQ-038 reset asserted on 2nd payload beat of wc=8 packet -> all outputs reset next cycle, FSM IDLE, following lp_en accepted normally.

Source files
------------

// File: rtl/csi2_pkt_mux.sv
// CSI-2 packet multiplexer: merges NUM_CH packet streams onto one output,
// keeping long packets atomic and counting packets it has to discard.
module csi2_pkt_mux #(
  parameter int RX_DATA_WIDTH = 8,
  parameter int NUM_CH        = 4,
  parameter int ARB_MODE      = 0,
  parameter int VC_REMAP      = 0,
  localparam int SELW         = $clog2(NUM_CH),
  localparam int BPB          = RX_DATA_WIDTH / 8
) (
  input  logic                            clk_byte,
  input  logic                            reset,
  input  logic [SELW-1:0]                 mux_sel,
  input  logic [NUM_CH-1:0]               lp_en,
  input  logic [NUM_CH-1:0]               sp_en,
  input  logic [NUM_CH-1:0]               d2c_payload_en,
  input  logic [NUM_CH*RX_DATA_WIDTH-1:0] d2c_data,
  input  logic [NUM_CH*16-1:0]            wc,
  input  logic [NUM_CH*2-1:0]             vc,
  input  logic [NUM_CH*6-1:0]             dt,
  output logic                            lp_en_mux,
  output logic                            sp_en_mux,
  output logic                            d2c_payload_en_mux,
  output logic [RX_DATA_WIDTH-1:0]        d2c_data_mux,
  output logic [15:0]                     wc_mux,
  output logic [1:0]                      vc_mux,
  output logic [5:0]                      dt_mux,
  output logic [SELW-1:0]                 cur_ch,
  output logic [15:0]                     drop_cnt
);

  typedef enum logic {IDLE, LONG} state_t;

  state_t                   r_state, w_state;
  logic [SELW-1:0]          r_owner, w_owner;
  logic [SELW-1:0]          r_last, w_last;
  logic [SELW-1:0]          r_cur, w_cur;
  logic [15:0]              r_rem, w_rem;
  logic                     r_lp, w_lp;
  logic                     r_sp, w_sp;
  logic                     r_pe, w_pe;
  logic [RX_DATA_WIDTH-1:0] r_data, w_data;
  logic [15:0]              r_wc, w_wc;
  logic [1:0]               r_vc, w_vc;
  logic [5:0]               r_dt, w_dt;
  logic [15:0]              r_drop, w_drop;

  logic [SELW-1:0]          w_cand;
  logic                     w_cvalid;
  logic                     w_clp;
  logic                     w_csp;
  logic [15:0]              w_cwc;
  logic [1:0]               w_cvc;
  logic [5:0]               w_cdt;
  logic                     w_fwd;
  logic [16:0]              w_sum;

  // Round-robin search starts just past the last grant.
  always_comb begin
    w_cand = mux_sel;
    if (ARB_MODE == 1) begin
      logic w_found;
      w_found = 1'b0;
      w_cand  = r_last;
      for (int i = 1; i <= NUM_CH; i++) begin
        int k;
        k = (int'(r_last) + i) % NUM_CH;
        if (!w_found && (lp_en[k] || sp_en[k])) begin
          w_found = 1'b1;
          w_cand  = SELW'(k);
        end
      end
    end
  end

  always_comb begin
    w_cvalid = int'(w_cand) < NUM_CH;
    w_clp    = w_cvalid && lp_en[w_cand];
    w_csp    = w_cvalid && sp_en[w_cand];
    w_cwc    = wc[int'(w_cand)*16 +: 16];
    w_cdt    = dt[int'(w_cand)*6 +: 6];
    w_cvc    = (VC_REMAP == 1) ? 2'(w_cand)
                               : vc[int'(w_cand)*2 +: 2];
  end

  always_comb begin
    w_state = r_state;
    w_owner = r_owner;
    w_last  = r_last;
    w_cur   = r_cur;
    w_rem   = r_rem;
    w_lp    = 1'b0;
    w_sp    = 1'b0;
    w_pe    = 1'b0;
    w_data  = r_data;
    w_wc    = r_wc;
    w_vc    = r_vc;
    w_dt    = r_dt;
    w_fwd   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_clp || w_csp) begin
          w_fwd  = 1'b1;
          w_lp   = w_clp;
          w_sp   = !w_clp;
          w_wc   = w_cwc;
          w_vc   = w_cvc;
          w_dt   = w_cdt;
          w_last = w_cand;
          w_cur  = w_cand;
        end
        // A zero-length long packet has no payload to wait for.
        if (w_clp && (w_cwc != 16'd0)) begin
          w_state = LONG;
          w_owner = w_cand;
          w_rem   = w_cwc;
        end
      end
      LONG: begin
        if (d2c_payload_en[r_owner]) begin
          w_pe   = 1'b1;
          w_data = d2c_data[int'(r_owner)*RX_DATA_WIDTH +: RX_DATA_WIDTH];
          if (r_rem <= 16'(BPB)) begin
            w_state = IDLE;
            w_rem   = 16'd0;
          end else begin
            w_rem = r_rem - 16'(BPB);
          end
        end
      end
      default: w_state = IDLE;
    endcase
  end

  always_comb begin
    w_sum = {1'b0, r_drop}
          + 17'($countones(lp_en))
          + 17'($countones(sp_en))
          - 17'(w_fwd);
    w_drop = w_sum[16] ? 16'hFFFF : w_sum[15:0];
  end

  always_ff @(posedge clk_byte) begin
    if (reset) begin
      r_state <= IDLE;
      r_owner <= '0;
      r_last  <= SELW'(NUM_CH - 1);
      r_cur   <= '0;
      r_rem   <= '0;
      r_lp    <= 1'b0;
      r_sp    <= 1'b0;
      r_pe    <= 1'b0;
      r_data  <= '0;
      r_wc    <= '0;
      r_vc    <= '0;
      r_dt    <= '0;
      r_drop  <= '0;
    end else begin
      r_state <= w_state;
      r_owner <= w_owner;
      r_last  <= w_last;
      r_cur   <= w_cur;
      r_rem   <= w_rem;
      r_lp    <= w_lp;
      r_sp    <= w_sp;
      r_pe    <= w_pe;
      r_data  <= w_data;
      r_wc    <= w_wc;
      r_vc    <= w_vc;
      r_dt    <= w_dt;
      r_drop  <= w_drop;
    end
  end

  assign lp_en_mux          = r_lp;
  assign sp_en_mux          = r_sp;
  assign d2c_payload_en_mux = r_pe;
  assign d2c_data_mux       = r_data;
  assign wc_mux             = r_wc;
  assign vc_mux             = r_vc;
  assign dt_mux             = r_dt;
  assign cur_ch             = r_cur;
  assign drop_cnt           = r_drop;

endmodule

// File: tb/tb_csi2_pkt_mux.sv
// Bench for csi2_pkt_mux: three instances (host-select, round-robin,
// host-select with VC remap) share one stimulus bus.
module tb_csi2_pkt_mux;

  localparam int DW = 8;
  localparam int NC = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic [SW-1:0] mux_sel;
  logic [NC-1:0] lp_en, sp_en, pe;
  logic [NC*DW-1:0] data;
  logic [NC*16-1:0] wc;
  logic [NC*2-1:0]  vc;
  logic [NC*6-1:0]  dt;

  logic          lp0, sp0, pe0, lp1, sp1, pe1, lp2, sp2, pe2;
  logic [DW-1:0] d0, d1, d2;
  logic [15:0]   wc0, wc1, wc2, dr0, dr1, dr2;
  logic [1:0]    vc0, vc1, vc2;
  logic [5:0]    dt0, dt1, dt2;
  logic [SW-1:0] cc0, cc1, cc2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  csi2_pkt_mux #(.RX_DATA_WIDTH(DW), .NUM_CH(NC),
                 .ARB_MODE(0), .VC_REMAP(0)) dut0 (
    .clk_byte(clk), .reset(reset), .mux_sel(mux_sel),
    .lp_en(lp_en), .sp_en(sp_en), .d2c_payload_en(pe),
    .d2c_data(data), .wc(wc), .vc(vc), .dt(dt),
    .lp_en_mux(lp0), .sp_en_mux(sp0),
    .d2c_payload_en_mux(pe0), .d2c_data_mux(d0),
    .wc_mux(wc0), .vc_mux(vc0), .dt_mux(dt0),
    .cur_ch(cc0), .drop_cnt(dr0));

  csi2_pkt_mux #(.RX_DATA_WIDTH(DW), .NUM_CH(NC),
                 .ARB_MODE(1), .VC_REMAP(0)) dut1 (
    .clk_byte(clk), .reset(reset), .mux_sel(mux_sel),
    .lp_en(lp_en), .sp_en(sp_en), .d2c_payload_en(pe),
    .d2c_data(data), .wc(wc), .vc(vc), .dt(dt),
    .lp_en_mux(lp1), .sp_en_mux(sp1),
    .d2c_payload_en_mux(pe1), .d2c_data_mux(d1),
    .wc_mux(wc1), .vc_mux(vc1), .dt_mux(dt1),
    .cur_ch(cc1), .drop_cnt(dr1));

  csi2_pkt_mux #(.RX_DATA_WIDTH(DW), .NUM_CH(NC),
                 .ARB_MODE(0), .VC_REMAP(1)) dut2 (
    .clk_byte(clk), .reset(reset), .mux_sel(mux_sel),
    .lp_en(lp_en), .sp_en(sp_en), .d2c_payload_en(pe),
    .d2c_data(data), .wc(wc), .vc(vc), .dt(dt),
    .lp_en_mux(lp2), .sp_en_mux(sp2),
    .d2c_payload_en_mux(pe2), .d2c_data_mux(d2),
    .wc_mux(wc2), .vc_mux(vc2), .dt_mux(dt2),
    .cur_ch(cc2), .drop_cnt(dr2));

  typedef struct {
    logic [1:0]  sel;
    logic [3:0]  sp;
    logic        e_sp;
    logic [15:0] e_wc;
    logic [1:0]  e_vc;
    logic [5:0]  e_dt;
    logic [1:0]  e_cur;
    logic [15:0] e_drop;
  } vec_t;

  vec_t tbl[6];

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic defaults();
    lp_en = '0;
    sp_en = '0;
    pe    = '0;
    for (int i = 0; i < NC; i++) begin
      wc[i*16 +: 16] = 16'hA000 + 16'(i);
      vc[i*2 +: 2]   = 2'(3 - i);
      dt[i*6 +: 6]   = 6'h10 + 6'(i);
      data[i*DW +: DW] = 8'hD0 + 8'(i);
    end
  endtask

  task automatic do_reset();
    defaults();
    mux_sel = '0;
    reset   = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  initial begin
    tbl[0] = '{2'd1, 4'b0010, 1'b1, 16'hA001, 2'd2, 6'h11, 2'd1, 16'd0};
    tbl[1] = '{2'd1, 4'b0100, 1'b0, 16'hA001, 2'd2, 6'h11, 2'd1, 16'd1};
    tbl[2] = '{2'd3, 4'b1111, 1'b1, 16'hA003, 2'd0, 6'h13, 2'd3, 16'd4};
    tbl[3] = '{2'd0, 4'b0000, 1'b0, 16'hA003, 2'd0, 6'h13, 2'd3, 16'd4};
    tbl[4] = '{2'd2, 4'b0101, 1'b1, 16'hA002, 2'd1, 6'h12, 2'd2, 16'd5};
    tbl[5] = '{2'd0, 4'b0001, 1'b1, 16'hA000, 2'd3, 6'h10, 2'd0, 16'd5};

    do_reset();
    check("rst_lp", 32'(lp0), 0);
    check("rst_sp", 32'(sp0), 0);
    check("rst_pe", 32'(pe0), 0);
    check("rst_data", 32'(d0), 0);
    check("rst_wc", 32'(wc0), 0);
    check("rst_cur", 32'(cc0), 0);
    check("rst_drop", 32'(dr0), 0);

    for (int v = 0; v < 6; v++) begin
      mux_sel = tbl[v].sel;
      sp_en   = tbl[v].sp;
      tick();
      sp_en = '0;
      check($sformatf("v%0d_sp", v), 32'(sp0), 32'(tbl[v].e_sp));
      check($sformatf("v%0d_lp", v), 32'(lp0), 0);
      check($sformatf("v%0d_wc", v), 32'(wc0), 32'(tbl[v].e_wc));
      check($sformatf("v%0d_vc", v), 32'(vc0), 32'(tbl[v].e_vc));
      check($sformatf("v%0d_dt", v), 32'(dt0), 32'(tbl[v].e_dt));
      check($sformatf("v%0d_cur", v), 32'(cc0), 32'(tbl[v].e_cur));
      check($sformatf("v%0d_drop", v), 32'(dr0), 32'(tbl[v].e_drop));
    end

    // Long packet of 4 bytes on channel 2, channel 1 payload noise
    do_reset();
    mux_sel = 2'd2;
    wc[2*16 +: 16] = 16'd4;
    lp_en = 4'b0100;
    tick();
    lp_en = '0;
    check("lp_hdr", 32'(lp0), 1);
    check("lp_wc", 32'(wc0), 4);
    check("lp_cur", 32'(cc0), 2);
    for (int k = 0; k < 4; k++) begin
      pe = 4'b0110;
      data[2*DW +: DW] = 8'h20 + 8'(k);
      data[1*DW +: DW] = 8'hEE;
      tick();
      check($sformatf("beat%0d_pe", k), 32'(pe0), 1);
      check($sformatf("beat%0d_d", k), 32'(d0), 32'h20 + k);
    end
    data[2*DW +: DW] = 8'h77;
    tick();
    check("post_pe", 32'(pe0), 0);
    check("post_hold", 32'(d0), 32'h23);
    pe = '0;
    sp_en = 4'b0100;
    tick();
    sp_en = '0;
    check("post_sp", 32'(sp0), 1);
    check("post_drop", 32'(dr0), 0);

    // Select change and foreign short packet mid-packet
    do_reset();
    mux_sel = 2'd1;
    wc[1*16 +: 16] = 16'd2;
    lp_en = 4'b0010;
    tick();
    lp_en = '0;
    mux_sel = 2'd3;
    check("sw_hdr", 32'(lp0), 1);
    pe = 4'b1010;
    data[1*DW +: DW] = 8'h31;
    data[3*DW +: DW] = 8'h99;
    sp_en = 4'b0100;
    tick();
    sp_en = '0;
    check("sw_b1_pe", 32'(pe0), 1);
    check("sw_b1_d", 32'(d0), 32'h31);
    check("sw_b1_sp", 32'(sp0), 0);
    check("sw_b1_drop", 32'(dr0), 1);
    check("sw_b1_cur", 32'(cc0), 1);
    data[1*DW +: DW] = 8'h32;
    tick();
    check("sw_b2_d", 32'(d0), 32'h32);
    pe = '0;
    sp_en = 4'b1000;
    tick();
    sp_en = '0;
    check("sw_new_sp", 32'(sp0), 1);
    check("sw_new_cur", 32'(cc0), 3);
    check("sw_new_drop", 32'(dr0), 1);

    // Round-robin arbitration
    do_reset();
    wc[0*16 +: 16] = 16'd1;
    wc[3*16 +: 16] = 16'd1;
    lp_en = 4'b1001;
    tick();
    lp_en = '0;
    check("rr1_lp", 32'(lp1), 1);
    check("rr1_cur", 32'(cc1), 0);
    check("rr1_drop", 32'(dr1), 1);
    pe = 4'b0001;
    tick();
    pe = '0;
    check("rr1_pe", 32'(pe1), 1);
    lp_en = 4'b1001;
    tick();
    lp_en = '0;
    check("rr2_lp", 32'(lp1), 1);
    check("rr2_cur", 32'(cc1), 3);
    check("rr2_drop", 32'(dr1), 2);

    // VC remap and drop counter saturation
    do_reset();
    mux_sel = 2'd3;
    sp_en = 4'b1000;
    tick();
    sp_en = '0;
    check("remap_sp", 32'(sp2), 1);
    check("remap_vc", 32'(vc2), 3);
    wc[3*16 +: 16] = 16'hFFFF;
    lp_en = 4'b1111;
    sp_en = 4'b1111;
    tick();
    tick();
    check("sat_early", 32'(dr2), 15);
    for (int n = 0; n < 8200; n++) tick();
    check("sat_hold", 32'(dr2), 32'hFFFF);
    tick();
    check("sat_hold2", 32'(dr2), 32'hFFFF);

    // Reset in the middle of a long packet
    do_reset();
    wc[0*16 +: 16] = 16'd8;
    lp_en = 4'b0001;
    tick();
    lp_en = '0;
    pe = 4'b0001;
    data[0*DW +: DW] = 8'h41;
    tick();
    check("mr_b1", 32'(pe0), 1);
    data[0*DW +: DW] = 8'h42;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mr_pe", 32'(pe0), 0);
    check("mr_data", 32'(d0), 0);
    check("mr_wc", 32'(wc0), 0);
    check("mr_cur", 32'(cc0), 0);
    data[0*DW +: DW] = 8'h43;
    tick();
    check("mr_nobeat", 32'(pe0), 0);
    pe = '0;
    lp_en = 4'b0001;
    tick();
    lp_en = '0;
    check("mr_relp", 32'(lp0), 1);
    check("mr_rewc", 32'(wc0), 8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
